fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide the following ports:
  - clk  in  1  system clock; all state on rising edge.
  - rst  in  1  asynchronous reset, active-low; state clears while rst=0.
  - PC  in  32  current fetch address from the PC stage.
  - PCPlus4  in  32  PC+4 from the PC stage.
  - redirect  in  1  execute-stage redirect (PCSrc != 00) this cycle.
  - pc_en  out  1  enable to the PC stage; PC register advances when high.
  - imem_req  out  1  instruction-memory request valid.
  - imem_addr  out  32  request address.
  - imem_gnt  in  1  request accepted this cycle.
  - imem_rvalid  in  1  response data valid.
  - imem_rdata  in  32  response instruction word.
  - valid_d  out  1  head entry valid to decode.
  - ready_d  in  1  decode accepts head; low during decode stall.
  - InstrD  out  32  head instruction.
  - PCD  out  32  head PC.
  - PCPlus4D  out  32  head PC+4.

Function
REQ-003 The block SHALL hold a 2-entry FIFO; each entry is {instr, pc, pcplus4} (96 bits).
REQ-004 The block SHALL keep at most one memory request outstanding.
REQ-005 The request-control FSM SHALL have three states:
  - IDLE: nothing outstanding.
  - WAIT: response pending, to be kept.
  - DROP: response pending, to be discarded.
REQ-006 The block SHALL compute imem_req = (state==IDLE) & (count < 2) & !redirect, where count is the FIFO occupancy.
REQ-007 The block SHALL drive imem_addr = PC combinationally.
REQ-008 On imem_req & imem_gnt, the block SHALL latch PC/PCPlus4 into pending registers and go IDLE->WAIT.
REQ-009 The block SHALL drive pc_en = redirect | (imem_req & imem_gnt).
  - The PC stage holds otherwise.
REQ-010 In WAIT with imem_rvalid & !redirect, the block SHALL push {imem_rdata, pending pc, pending pcplus4} and go to IDLE.
REQ-011 In WAIT with redirect & !imem_rvalid, the block SHALL go to DROP.
REQ-012 In WAIT with redirect & imem_rvalid, the block SHALL discard the data and go to IDLE.
REQ-013 In DROP, the block SHALL discard imem_rvalid data, go to IDLE, and push nothing.
  - A redirect in DROP keeps the state DROP.
REQ-014 The block SHALL pop the head when valid_d & ready_d.
  - A simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-015 Overflow SHALL be impossible: a request issues only when count<2 with nothing outstanding.
  - A push into a full FIFO is an assertion failure.
REQ-016 On redirect, count SHALL become 0 at the next edge, overriding any push or pop that cycle.
  - valid_d SHALL be 0 in the following cycle.
REQ-017 The block SHALL drive valid_d = (count != 0).
  - InstrD/PCD/PCPlus4D come from the head entry when valid.
  - When empty, InstrD=32'h00000013 (NOP), PCD=0, PCPlus4D=0.
REQ-018 Read and write pointers SHALL be 1 bit each and wrap 1->0.
  - count SHALL be 2 bits, range 0..2.
REQ-019 Minimum latency SHALL be 2 cycles from grant to valid_d: gnt at cycle N, rvalid at N+1, valid_d at N+2.
  - Back-to-back requests SHALL be one per two cycles with zero-wait memory.

Reset
REQ-020 While rst=0, the block SHALL hold state=IDLE, count=0, pointers=0, pending registers=0, valid_d=0, InstrD=32'h00000013, PCD=0 and PCPlus4D=0.
  - imem_req follows REQ-006, so it is 1 when PC is valid and redirect=0.
REQ-021 Reset asserted mid-operation, including in WAIT or DROP, SHALL clear all state immediately.
  - A response arriving after reset release with no request issued SHALL be ignored (state IDLE).

Verification
REQ-022 Basic fetch:
  - Stimulus: PC=0x0, gnt=1, rvalid next cycle with rdata=0x00500093, ready_d=1.
  - Response: valid_d=1 with InstrD=0x00500093, PCD=0x0, PCPlus4D=0x4; pc_en pulses once per request.
REQ-023 Fill and stall:
  - Stimulus: ready_d=0, two fetches at PC=0x0 and 0x4.
  - Response: count=2, imem_req=0, pc_en=0; then ready_d=1 for one cycle pops PCD=0x0, and imem_req reasserts.
REQ-024 Redirect with response pending:
  - Stimulus: request at PC=0x8 granted; next cycle redirect=1 with rvalid=0.
  - Response: state DROP; the later rvalid data 0xDEADBEEF is never visible; valid_d=0; pc_en=1 on the redirect cycle.
REQ-025 Redirect coincident with rvalid:
  - Stimulus: redirect=1 and rvalid=1 in the same cycle, FIFO holding 1 entry.
  - Response: FIFO empty next cycle, InstrD=0x00000013, state IDLE.
REQ-026 Simultaneous push and pop:
  - Stimulus: count=1, rvalid and ready_d in the same cycle.
  - Response: count stays 1, the head advances to the new entry, and order is preserved.
REQ-027 Async reset:
  - Stimulus: rst=0 asserted between clock edges while in WAIT.
  - Response: valid_d=0 and state IDLE without waiting for a clock edge; after release, rvalid=1 with no request granted pushes nothing.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: a single-outstanding memory request engine that feeds a
// 2-entry {instr, pc, pc+4} FIFO in front of decode, with redirect flush and response drop.
module fetch_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [31:0] PCPlus4,
    input  logic        redirect,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_d,
    input  logic        ready_d,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  WAIT     = 2'd1;
    localparam logic [1:0]  DROP     = 2'd2;
    localparam logic [31:0] NopInstr = 32'h00000013;

    logic [1:0]  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] pend_pc_q, pend_pcp4_q;
    logic [31:0] instr_q [2];
    logic [31:0] pc_q    [2];
    logic [31:0] pcp4_q  [2];
    logic        grant, push, pop;

    assign imem_req  = (state_q == IDLE) && (count_q < 2'd2) && !redirect;
    assign imem_addr = PC;
    assign grant     = imem_req & imem_gnt;
    assign pc_en     = redirect | grant;
    // A redirect in the response cycle kills the data as well as the queue.
    assign push      = (state_q == WAIT) & imem_rvalid & ~redirect;
    assign valid_d   = (count_q != 2'd0);
    assign pop       = valid_d & ready_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            pend_pc_q   <= 32'd0;
            pend_pcp4_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (grant) begin
                pend_pc_q   <= PC;
                pend_pcp4_q <= PCPlus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= 32'd0;
                pc_q[i]    <= 32'd0;
                pcp4_q[i]  <= 32'd0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]    <= pend_pc_q;
            pcp4_q[wr_ptr_q]  <= pend_pcp4_q;
        end
    end

    always_comb begin
        InstrD   = NopInstr;
        PCD      = 32'd0;
        PCPlus4D = 32'd0;
        if (valid_d) begin
            InstrD   = instr_q[rd_ptr_q];
            PCD      = pc_q[rd_ptr_q];
            PCPlus4D = pcp4_q[rd_ptr_q];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && count_q == 2'd2));

endmodule
